// File: rtl/tdc_stream_pkg.sv
// Shared types and constants for the TDC timestamp stream transmitter.
// Optional build macro: TDC_STREAM_SATURATE_EN (see tdc_slot_buf).
package tdc_stream_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } tdc_tx_state_t;

   // Widest timestamp supported; narrower builds slice NO_HIT down to NP bits.
   localparam int NP_MAX = 32;
   localparam logic [NP_MAX-1:0] NO_HIT = '1;

   // Pixel and acquisition index widths seen by the histogram builder.
   localparam int PIX_W = 8;
   localparam int ACQ_W = 20;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tdc_slot_buf.sv
// Pixel holding register plus slot mux with no-hit substitution.
// Build macro TDC_STREAM_SATURATE_EN clamps a valid all-ones hit to all-ones minus one.
module tdc_slot_buf
   import tdc_stream_pkg::*;
#(
   parameter int NP       = 10,
   parameter int DATA_NUM = 2,
   parameter int SLOT_W   = 1
) (
   input  logic                   clk,
   input  logic                   load,
   input  logic [DATA_NUM*NP-1:0] in_data,
   input  logic [DATA_NUM-1:0]    in_hit,
   input  logic [SLOT_W-1:0]      sel,
   output logic [NP-1:0]          word
);

   logic [DATA_NUM*NP-1:0] buf_data;
   logic [DATA_NUM-1:0]    buf_hit;
   logic [DATA_NUM*NP-1:0] src_data;
   logic [DATA_NUM-1:0]    src_hit;
   logic [NP-1:0]          slot_val;

   // NOTE: the holding register carries no reset; it is only read after a load,
   // so clearing it would add reset fan-out without changing any output.
   always_ff @(posedge clk) begin
      if (load) begin
         buf_data <= in_data;
         buf_hit  <= in_hit;
      end
   end

   // On a load cycle slot 0 is taken straight from the incoming bundle so it
   // can be registered onto the output in the same edge.
   always_comb begin
      src_data = load ? in_data : buf_data;
      src_hit  = load ? in_hit  : buf_hit;
      slot_val = src_data[int'(sel)*NP +: NP];
      word     = NO_HIT[NP-1:0];
      if (src_hit[sel]) begin
`ifdef TDC_STREAM_SATURATE_EN
         word = (slot_val == NO_HIT[NP-1:0]) ? (NO_HIT[NP-1:0] - 1'b1) : slot_val;
`else
         word = slot_val;
`endif
      end
   end

endmodule

// File: rtl/tdc_stream_tx.sv
// Serialises per-pixel TDC timestamp bundles into the histogram builder word stream,
// with frame-end idle gap. Build macro TDC_STREAM_SATURATE_EN is handled in tdc_slot_buf.
module tdc_stream_tx
   import tdc_stream_pkg::*;
#(
   parameter int NP        = 10,
   parameter int DATA_NUM  = 2,
   parameter int PIXEL_NUM = 200,
   parameter int ACQ_NUM   = 33333,
   parameter int FRAME_GAP = 4
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_NUM*NP-1:0] in_data,
   input  logic [DATA_NUM-1:0]    in_hit,
   output logic                   wrEn,
   output logic [NP-1:0]          data,
   output logic [PIX_W-1:0]       pix_idx,
   output logic [ACQ_W-1:0]       acq_idx,
   output logic                   frame_done
);

   localparam int SLOT_W = cnt_width(DATA_NUM);
   localparam int GAP_W  = cnt_width(FRAME_GAP);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DATA_NUM - 1);
   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXEL_NUM - 1);
   localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(ACQ_NUM - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FRAME_GAP - 1);

   tdc_tx_state_t     state;
   logic [SLOT_W-1:0] slot_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   logic              last;
   logic              frame_end;
   logic              take;
   logic              emit;
   logic [SLOT_W-1:0] next_slot;
   logic [PIX_W-1:0]  pix_adv;
   logic [ACQ_W-1:0]  acq_adv;
   logic [PIX_W-1:0]  word_pix;
   logic [ACQ_W-1:0]  word_acq;
   logic              word_last;
   logic              word_fend;
   logic [NP-1:0]     word;

   tdc_slot_buf #(
      .NP       (NP),
      .DATA_NUM (DATA_NUM),
      .SLOT_W   (SLOT_W)
   ) u_slot_buf (
      .clk     (clk),
      .load    (take),
      .in_data (in_data),
      .in_hit  (in_hit),
      .sel     (next_slot),
      .word    (word)
   );

   // NOTE: every signal in this block gets a value before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      pix_adv   = pix_idx + 1'b1;
      acq_adv   = acq_idx;
      last      = (state == SEND) && (slot_cnt == SLOT_LAST);
      frame_end = last && (pix_idx == PIX_LAST) && (acq_idx == ACQ_LAST);
      // A frame end wins over a back-to-back accept; in_ready is low then anyway.
      take      = in_valid && in_ready && !res && !frame_end;
      emit      = ((state == SEND) && !last) || take;
      next_slot = ((state == SEND) && !last) ? (slot_cnt + 1'b1) : '0;

      if (pix_idx == PIX_LAST) begin
         pix_adv = '0;
         acq_adv = (acq_idx == ACQ_LAST) ? '0 : (acq_idx + 1'b1);
      end

      // Indices and flags describing the word that goes on data next edge.
      word_pix  = last ? pix_adv : pix_idx;
      word_acq  = last ? acq_adv : acq_idx;
      word_last = (next_slot == SLOT_LAST);
      word_fend = word_last && (word_pix == PIX_LAST) && (word_acq == ACQ_LAST);
   end

   // NOTE: state and outputs use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (res) begin
         state      <= IDLE;
         slot_cnt   <= '0;
         gap_cnt    <= '0;
         in_ready   <= 1'b0;
         wrEn       <= 1'b0;
         data       <= '0;
         pix_idx    <= '0;
         acq_idx    <= '0;
         frame_done <= 1'b0;
      end else begin
         wrEn       <= emit;
         frame_done <= emit && word_fend;
         if (emit) begin
            slot_cnt <= next_slot;
            data     <= word;
         end
         if (last) begin
            pix_idx <= pix_adv;
            acq_idx <= acq_adv;
         end

         case (state)
            IDLE: begin
               if (take) begin
                  state    <= SEND;
                  in_ready <= word_last && !word_fend;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SEND: begin
               if (frame_end) begin
                  gap_cnt <= '0;
                  if (FRAME_GAP == 0) begin
                     state    <= IDLE;
                     in_ready <= 1'b1;
                  end else begin
                     state    <= GAP;
                     in_ready <= 1'b0;
                  end
               end else if (emit) begin
                  in_ready <= word_last && !word_fend;
               end else begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end else begin
                  gap_cnt  <= gap_cnt + 1'b1;
                  in_ready <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_stream_tx.sv
// Directed self-checking bench for tdc_stream_tx with a small frame
// (3 pixels x 2 acquisitions x 2 slots, 4-cycle frame gap).
module tb_tdc_stream_tx;

   localparam int NP        = 10;
   localparam int DATA_NUM  = 2;
   localparam int PIXEL_NUM = 3;
   localparam int ACQ_NUM   = 2;
   localparam int FRAME_GAP = 4;

   logic                   clk;
   logic                   res;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_NUM*NP-1:0] in_data;
   logic [DATA_NUM-1:0]    in_hit;
   logic                   wrEn;
   logic [NP-1:0]          data;
   logic [7:0]             pix_idx;
   logic [19:0]            acq_idx;
   logic                   frame_done;

   int checks   = 0;
   int failures = 0;
   int fd_count = 0;

   tdc_stream_tx #(
      .NP        (NP),
      .DATA_NUM  (DATA_NUM),
      .PIXEL_NUM (PIXEL_NUM),
      .ACQ_NUM   (ACQ_NUM),
      .FRAME_GAP (FRAME_GAP)
   ) dut (
      .clk        (clk),
      .res        (res),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_hit     (in_hit),
      .wrEn       (wrEn),
      .data       (data),
      .pix_idx    (pix_idx),
      .acq_idx    (acq_idx),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_count++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      res      = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      res = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      res      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_hit   = '0;
      tick();
      tick();
      checks++;
      if ({wrEn, data, pix_idx, acq_idx, frame_done, in_ready} !== '0) begin
         failures++;
         $display("FAIL reset_state: got wrEn=%b data=%h pix=%0d acq=%0d fd=%b rdy=%b, want all zero",
                  wrEn, data, pix_idx, acq_idx, frame_done, in_ready);
      end
      res = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_single_pixel();
      in_data  = {10'h120, 10'h005};
      in_hit   = 2'b11;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wrEn, data, pix_idx, in_ready} !== {1'b1, 10'h005, 8'd0, 1'b0}) begin
         failures++;
         $display("FAIL single_w0: got wrEn=%b data=%h pix=%0d rdy=%b, want 1 005 0 0",
                  wrEn, data, pix_idx, in_ready);
      end
      tick();
      checks++;
      if ({wrEn, data, pix_idx, in_ready} !== {1'b1, 10'h120, 8'd0, 1'b1}) begin
         failures++;
         $display("FAIL single_w1: got wrEn=%b data=%h pix=%0d rdy=%b, want 1 120 0 1",
                  wrEn, data, pix_idx, in_ready);
      end
      tick();
      checks++;
      if ({wrEn, pix_idx, acq_idx, in_ready} !== {1'b0, 8'd1, 20'd0, 1'b1}) begin
         failures++;
         $display("FAIL single_after: got wrEn=%b pix=%0d acq=%0d rdy=%b, want 0 1 0 1",
                  wrEn, pix_idx, acq_idx, in_ready);
      end
   endtask

   task automatic test_no_hit();
      int n;
      in_data  = {10'h0AA, 10'h055};
      in_hit   = 2'b01;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wrEn, data} !== {1'b1, 10'h055}) begin
         failures++;
         $display("FAIL nohit_w0: got wrEn=%b data=%h, want 1 055", wrEn, data);
      end
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (wrEn === 1'b1) n++;
         tick();
         if (i == 0) begin
            checks++;
            if ({wrEn, data} !== {1'b1, 10'h3FF}) begin
               failures++;
               $display("FAIL nohit_w1: got wrEn=%b data=%h, want 1 3ff", wrEn, data);
            end
         end
      end
      checks++;
      if (n !== 2) begin
         failures++;
         $display("FAIL nohit_count: got %0d words want 2", n);
      end
   endtask

   task automatic test_saturate();
      logic [NP-1:0] sat_exp;
`ifdef TDC_STREAM_SATURATE_EN
      sat_exp = 10'h3FE;
`else
      sat_exp = 10'h3FF;
`endif
      in_data  = {10'h3FF, 10'h001};
      in_hit   = 2'b11;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wrEn, data, pix_idx, acq_idx} !== {1'b1, 10'h001, 8'd2, 20'd0}) begin
         failures++;
         $display("FAIL sat_w0: got wrEn=%b data=%h pix=%0d acq=%0d, want 1 001 2 0",
                  wrEn, data, pix_idx, acq_idx);
      end
      tick();
      checks++;
      if ({wrEn, data} !== {1'b1, sat_exp}) begin
         failures++;
         $display("FAIL sat_w1: got wrEn=%b data=%h, want 1 %h", wrEn, data, sat_exp);
      end
      tick();
      checks++;
      if ({pix_idx, acq_idx, frame_done} !== {8'd0, 20'd1, 1'b0}) begin
         failures++;
         $display("FAIL sat_wrap: got pix=%0d acq=%0d fd=%b, want 0 1 0", pix_idx, acq_idx, frame_done);
      end
   endtask

   task automatic test_reset_mid();
      int fd_before;
      fd_before = fd_count;
      in_data   = {10'h222, 10'h111};
      in_hit    = 2'b11;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if ({wrEn, data, pix_idx, acq_idx} !== {1'b1, 10'h111, 8'd2, 20'd1}) begin
         failures++;
         $display("FAIL resmid_pre: got wrEn=%b data=%h pix=%0d acq=%0d, want 1 111 2 1",
                  wrEn, data, pix_idx, acq_idx);
      end
      res      = 1'b1;
      in_valid = 1'b0;
      tick();
      checks++;
      if ({wrEn, pix_idx, acq_idx, in_ready} !== {1'b0, 8'd0, 20'd0, 1'b0}) begin
         failures++;
         $display("FAIL resmid_clear: got wrEn=%b pix=%0d acq=%0d rdy=%b, want 0 0 0 0",
                  wrEn, pix_idx, acq_idx, in_ready);
      end
      res = 1'b0;
      tick();
      tick();
      checks++;
      if (fd_count !== fd_before) begin
         failures++;
         $display("FAIL resmid_no_fd: got %0d frame_done pulses want %0d", fd_count, fd_before);
      end
      in_data  = {10'h044, 10'h033};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wrEn, data, pix_idx, acq_idx} !== {1'b1, 10'h033, 8'd0, 20'd0}) begin
         failures++;
         $display("FAIL resmid_after: got wrEn=%b data=%h pix=%0d acq=%0d, want 1 033 0 0",
                  wrEn, data, pix_idx, acq_idx);
      end
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int            waited;
      int            fd_before;
      logic [NP-1:0] exp_data;
      logic [7:0]    exp_pix;
      logic [19:0]   exp_acq;
      logic          exp_fd;
      logic          exp_rdy;
      do_reset();
      fd_before = fd_count;
      in_data   = {10'h011, 10'h010};
      in_hit    = 2'b11;
      in_valid  = 1'b1;
      waited    = 0;
      tick();
      while (wrEn !== 1'b1 && waited < 8) begin
         tick();
         waited++;
      end
      checks++;
      if (wrEn !== 1'b1) begin
         failures++;
         $display("FAIL b2b_start: got wrEn=%b after %0d cycles want 1", wrEn, waited);
      end
      for (int w = 0; w < 12; w++) begin
         exp_data = (w % 2 == 0) ? 10'h010 : 10'h011;
         exp_pix  = 8'((w / 2) % 3);
         exp_acq  = 20'(w / 6);
         exp_fd   = (w == 11);
         exp_rdy  = (w % 2 == 1) && (w != 11);
         checks++;
         if ({wrEn, data, pix_idx, acq_idx, frame_done, in_ready} !==
             {1'b1, exp_data, exp_pix, exp_acq, exp_fd, exp_rdy}) begin
            failures++;
            $display("FAIL b2b_word%0d: got wrEn=%b data=%h pix=%0d acq=%0d fd=%b rdy=%b, want 1 %h %0d %0d %b %b",
                     w, wrEn, data, pix_idx, acq_idx, frame_done, in_ready,
                     exp_data, exp_pix, exp_acq, exp_fd, exp_rdy);
         end
         tick();
      end
      for (int g = 0; g < FRAME_GAP; g++) begin
         checks++;
         if ({wrEn, in_ready, pix_idx, acq_idx} !== {1'b0, 1'b0, 8'd0, 20'd0}) begin
            failures++;
            $display("FAIL gap%0d: got wrEn=%b rdy=%b pix=%0d acq=%0d, want 0 0 0 0",
                     g, wrEn, in_ready, pix_idx, acq_idx);
         end
         tick();
      end
      checks++;
      if ({wrEn, in_ready} !== {1'b0, 1'b1}) begin
         failures++;
         $display("FAIL gap_exit: got wrEn=%b rdy=%b, want 0 1", wrEn, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wrEn, data, pix_idx, acq_idx} !== {1'b1, 10'h010, 8'd0, 20'd0}) begin
         failures++;
         $display("FAIL gap_held_accept: got wrEn=%b data=%h pix=%0d acq=%0d, want 1 010 0 0",
                  wrEn, data, pix_idx, acq_idx);
      end
      checks++;
      if (fd_count - fd_before !== 1) begin
         failures++;
         $display("FAIL b2b_fd_count: got %0d pulses want 1", fd_count - fd_before);
      end
      tick();
      tick();
   endtask

   initial begin
      res      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_hit   = '0;
      test_reset();
      test_single_pixel();
      test_no_hit();
      test_saturate();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
